// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator result path: register offsets,
// STATUS bit positions and the fp16 result type.
package acc_pkg;

  typedef logic [15:0] fp16_t;

  localparam logic [31:0] RES_STATUS_OFS = 32'h0000_0000;
  localparam logic [31:0] RES_DATA_OFS   = 32'h0000_0004;
  localparam logic [31:0] RES_CTRL_OFS   = 32'h0000_0008;

  localparam int ST_DONE_BIT  = 16;
  localparam int ST_OVF_BIT   = 17;
  localparam int ST_HALF_BIT  = 18;
  localparam int ST_EMPTY_BIT = 19;
  localparam int ST_FULL_BIT  = 20;

endpackage

// File: rtl/acc_sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous clear and synchronous
// active-low reset. The head word is presented combinationally on rdata.
module acc_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push && rst_n && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acc_result_collector.sv
// Packs fp16 datapath results two per word into a FIFO and serves them,
// plus a status word and a clear control, over a single-outstanding ICB slave.
module acc_result_collector
  import acc_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h1004_2100,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  fp16_t       res_data,
  input  logic        res_done,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        rdy_irq
);

  fp16_t            half_reg;
  logic             half_pending;
  logic             done_sticky;
  logic             ovf;
  logic             push_req;
  logic [31:0]      push_word;
  logic             pop;
  logic             clr;
  logic [31:0]      fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             cmd_accept;
  logic [31:0]      ofs;
  logic [31:0]      status;
  logic [31:0]      rdata_nxt;
  logic             err_nxt;
  logic             unused_bits;

  assign unused_bits   = ^{icb_cmd_wmask, icb_cmd_wdata[31:1]};
  assign icb_cmd_ready = !icb_rsp_valid || icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid && icb_cmd_ready;
  assign ofs           = icb_cmd_addr - BASE_ADDR;
  assign rdy_irq       = !fifo_empty && done_sticky;

  // A pending half is completed by a new result, or zero-padded once done has been seen.
  assign push_req  = half_pending && (res_valid || done_sticky);
  assign push_word = res_valid ? {res_data, half_reg} : {16'h0000, half_reg};

  // STATUS word assembly.
  always_comb begin
    status               = 32'h0000_0000;
    status[CNT_W-1:0]    = fifo_count;
    status[ST_DONE_BIT]  = done_sticky;
    status[ST_OVF_BIT]   = ovf;
    status[ST_HALF_BIT]  = half_pending;
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_FULL_BIT]  = fifo_full;
  end

  // Register decode: response data/error and the side effects taken at command acceptance.
  always_comb begin
    rdata_nxt = 32'h0000_0000;
    err_nxt   = 1'b1;
    pop       = 1'b0;
    clr       = 1'b0;
    if (icb_cmd_read) begin
      case (ofs)
        RES_STATUS_OFS: begin
          rdata_nxt = status;
          err_nxt   = 1'b0;
        end
        RES_DATA_OFS: begin
          if (!fifo_empty) begin
            rdata_nxt = fifo_head;
            err_nxt   = 1'b0;
            pop       = cmd_accept;
          end else begin
            err_nxt   = 1'b1;
          end
        end
        default: err_nxt = 1'b1;
      endcase
    end else begin
      case (ofs)
        RES_CTRL_OFS: begin
          err_nxt = 1'b0;
          clr     = cmd_accept && icb_cmd_wdata[0];
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  // Packer, done/overflow flags; a CTRL clear overrides everything in its cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_reg     <= 16'h0000;
      half_pending <= 1'b0;
      done_sticky  <= 1'b0;
      ovf          <= 1'b0;
    end else if (clr) begin
      half_pending <= 1'b0;
      done_sticky  <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (res_done) done_sticky <= 1'b1;
      if (push_req) begin
        half_pending <= 1'b0;
        if (fifo_full && !pop) ovf <= 1'b1;
      end else if (res_valid) begin
        half_reg     <= res_data;
        half_pending <= 1'b1;
      end
    end
  end

  // Response register, held until the master takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= 32'h0000_0000;
      icb_rsp_err   <= 1'b0;
    end else if (cmd_accept) begin
      icb_rsp_valid <= 1'b1;
      icb_rsp_rdata <= rdata_nxt;
      icb_rsp_err   <= err_nxt;
    end else if (icb_rsp_ready) begin
      icb_rsp_valid <= 1'b0;
    end
  end

  acc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push_req),
    .wdata (push_word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_acc_result_collector.sv
// Directed self-checking bench for acc_result_collector: packing, flush,
// overflow, error responses, response back-pressure and reset mid-transfer.
module tb_acc_result_collector;

  localparam logic [31:0] BASE   = 32'h1004_2100;
  localparam logic [31:0] A_STAT = BASE + 32'h0;
  localparam logic [31:0] A_DATA = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = 16'h0000;
  logic        res_done = 1'b0;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic        icb_cmd_read = 1'b1;
  logic [31:0] icb_cmd_addr = 32'h0;
  logic [31:0] icb_cmd_wdata = 32'h0;
  logic [3:0]  icb_cmd_wmask = 4'hF;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        rdy_irq;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  acc_result_collector #(.DEPTH(64), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data), .res_done(res_done),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .rdy_irq(rdy_irq)
  );

  task automatic icb_xfer(input logic rd_n, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdat, output logic err);
    int n;
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = rd_n; icb_cmd_addr = addr; icb_cmd_wdata = wd;
    icb_rsp_ready = 1'b1;
    n = 0;
    while (!icb_cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    n = 0;
    while (!icb_rsp_valid && n < 20) begin @(negedge clk); n++; end
    n_total++;
    if (n >= 20) $display("FAIL icb_timeout: no response for addr %h", addr);
    else n_pass++;
    rdat = icb_rsp_rdata;
    err  = icb_rsp_err;
  endtask

  task automatic feed(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = base + 16'(i);
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); res_done = 1'b1;
    @(negedge clk); res_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (icb_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", icb_rsp_valid); else n_pass++;
    n_total++; if (icb_rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", icb_rsp_rdata); else n_pass++;
    n_total++; if (icb_rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", icb_rsp_err); else n_pass++;
    n_total++; if (rdy_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", rdy_irq); else n_pass++;
    n_total++; if (icb_cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", icb_cmd_ready); else n_pass++;
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0008_0000) $display("FAIL rst_status: got %h want 00080000", rd); else n_pass++;
  endtask

  task automatic test_full_run();
    feed(16'h3C00, 120);
    pulse_done();
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0001_003C) $display("FAIL run_status: got %h want 0001003c", rd); else n_pass++;
    n_total++; if (rdy_irq !== 1'b1) $display("FAIL run_irq: got %b want 1", rdy_irq); else n_pass++;
    for (int k = 0; k < 60; k++) begin
      logic [15:0] lo, hi;
      lo = 16'h3C00 + 16'(2 * k);
      hi = lo + 16'h0001;
      icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
      n_total++;
      if (rd !== {hi, lo} || er !== 1'b0) $display("FAIL run_data[%0d]: got %h err %b want %h err 0", k, rd, er, {hi, lo});
      else n_pass++;
    end
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0009_0000) $display("FAIL run_final_status: got %h want 00090000", rd); else n_pass++;
    n_total++; if (rdy_irq !== 1'b0) $display("FAIL run_final_irq: got %b want 0", rdy_irq); else n_pass++;
    icb_xfer(1'b0, A_CTRL, 32'h1, rd, er);
  endtask

  task automatic test_flush();
    @(negedge clk); res_valid = 1'b1; res_data = 16'h1111;
    @(negedge clk); res_data = 16'h2222;
    @(negedge clk); res_data = 16'h3333;
    @(negedge clk); res_valid = 1'b0;
    pulse_done();
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0001_0002) $display("FAIL flush_status: got %h want 00010002", rd); else n_pass++;
    icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
    n_total++; if (rd !== 32'h2222_1111) $display("FAIL flush_word0: got %h want 22221111", rd); else n_pass++;
    icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0000_3333) $display("FAIL flush_word1: got %h want 00003333", rd); else n_pass++;
    icb_xfer(1'b0, A_CTRL, 32'h1, rd, er);
  endtask

  task automatic test_overflow();
    feed(16'h4000, 130);
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0012_0040) $display("FAIL ovf_status: got %h want 00120040", rd); else n_pass++;
    for (int k = 0; k < 64; k++) begin
      logic [15:0] lo;
      lo = 16'h4000 + 16'(2 * k);
      icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
      n_total++;
      if (rd !== {lo + 16'h0001, lo} || er !== 1'b0) $display("FAIL ovf_data[%0d]: got %h err %b want %h", k, rd, er, {lo + 16'h0001, lo});
      else n_pass++;
    end
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h000A_0000) $display("FAIL ovf_drained: got %h want 000a0000", rd); else n_pass++;
    icb_xfer(1'b0, A_CTRL, 32'h1, rd, er);
    n_total++; if (er !== 1'b0) $display("FAIL ctrl_write_err: got %b want 0", er); else n_pass++;
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0008_0000) $display("FAIL ovf_cleared: got %h want 00080000", rd); else n_pass++;
  endtask

  task automatic test_errors();
    icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL empty_read: got %h err %b want 0 err 1", rd, er); else n_pass++;
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0008_0000) $display("FAIL empty_read_count: got %h want 00080000", rd); else n_pass++;
    icb_xfer(1'b1, BASE + 32'hC, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL bad_ofs: got %h err %b want 0 err 1", rd, er); else n_pass++;
    icb_xfer(1'b0, A_STAT, 32'hFFFF_FFFF, rd, er);
    n_total++; if (er !== 1'b1) $display("FAIL wr_status: got err %b want 1", er); else n_pass++;
    icb_xfer(1'b1, A_CTRL, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0 || er !== 1'b1) $display("FAIL rd_ctrl: got %h err %b want 0 err 1", rd, er); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    feed(16'h0A00, 4);
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = A_DATA; icb_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    held = icb_rsp_rdata;
    n_total++; if (icb_rsp_valid !== 1'b1 || held !== 32'h0A01_0A00) $display("FAIL bp_first: got %h valid %b want 0a010a00", held, icb_rsp_valid); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (icb_cmd_ready !== 1'b0 || icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h0A01_0A00)
        $display("FAIL bp_hold[%0d]: got ready %b valid %b rdata %h want 0 1 0a010a00", c, icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata);
      else n_pass++;
      @(negedge clk);
    end
    icb_rsp_ready = 1'b1;
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL bp_one_pop: got %h want 00000001", rd); else n_pass++;
    icb_xfer(1'b1, A_DATA, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0A03_0A02) $display("FAIL bp_second: got %h want 0a030a02", rd); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    feed(16'h5000, 20);
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = A_STAT; icb_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    n_total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h0000_000A) $display("FAIL mid_pending: got valid %b rdata %h want 1 0000000a", icb_rsp_valid, icb_rsp_rdata); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (icb_rsp_valid !== 1'b0 || icb_rsp_rdata !== 32'h0) $display("FAIL mid_rst_rsp: got valid %b rdata %h want 0 0", icb_rsp_valid, icb_rsp_rdata); else n_pass++;
    rst_n = 1'b1; icb_rsp_ready = 1'b1;
    icb_xfer(1'b1, A_STAT, 32'h0, rd, er);
    n_total++; if (rd !== 32'h0008_0000) $display("FAIL mid_rst_status: got %h want 00080000", rd); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run();
    test_flush();
    test_overflow();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
